// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - sm510 program ROM, host download sequencing and CPU clock/reset bring-up
// Optional: define ROM_CHECKSUM_EN to add the checksum / load_count download telemetry outputs.
module rom_load_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int CLK_DIV    = 4,
    parameter int RESET_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [7:0]            rom_data,
    output logic                  cpu_clk_en,
    output logic                  cpu_reset,
    output logic                  running
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]            checksum,
    output logic [ADDR_WIDTH:0]   load_count
`endif
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   div_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            wr_accept;
    logic            div_stop;
    logic [7:0]      mem [0:(2**ADDR_WIDTH)-1];

    assign wr_accept = ioctl_download && ioctl_wr;
    // Freezing on the entry cycle too keeps cpu_clk_en out of LOAD and restarts the divider cleanly on exit.
    assign div_stop  = (state == LOAD) || (state_next == LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (ioctl_download) state_next = LOAD;
            LOAD: if (!ioctl_download) state_next = HOLD;
            HOLD: begin
                if (ioctl_download) begin
                    state_next = LOAD;
                end else if (cpu_clk_en && (hold_cnt == HOLD_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN:  if (ioctl_download) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_reset = 1'b1;
        running   = 1'b0;
        if (state == RUN) begin
            cpu_reset = 1'b0;
            running   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            cpu_clk_en <= 1'b0;
        end else if (div_stop) begin
            div_cnt    <= '0;
            cpu_clk_en <= 1'b0;
        end else begin
            cpu_clk_en <= (div_cnt == DIV_LAST);
            div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (state != HOLD) begin
            hold_cnt <= '0;
        end else if (cpu_clk_en) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[ioctl_addr] <= ioctl_data;
        end
    end

    // Fetch data advances only on CPU clock enables, giving the core its one-period read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_data <= '0;
        end else if (cpu_clk_en) begin
            rom_data <= mem[rom_addr];
        end
    end

`ifdef ROM_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum   <= '0;
            load_count <= '0;
        end else if ((state != LOAD) && (state_next == LOAD)) begin
            checksum   <= wr_accept ? ioctl_data : 8'h00;
            load_count <= wr_accept ? (ADDR_WIDTH+1)'(1) : '0;
        end else if (wr_accept) begin
            checksum <= checksum + ioctl_data;
            if (load_count != '1) begin
                load_count <= load_count + 1'b1;
            end
        end
    end
`endif

endmodule
